// File: rtl/mmio_out_ctrl_if.sv
// CPU store/load port bundle for the MMIO output controller.
// Master is the execute stage; slave is the controller decoding its own address window.
interface mmio_out_ctrl_if;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic        rd_hit;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_hit
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_hit
  );
endinterface

// File: rtl/mmio_out_ctrl.sv
// MMIO 7-seg/LED/PWM output controller: writes land on the strobe edge, reads return 1 cycle after rd_en, no backpressure.
// Optional LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module mmio_out_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DIGITS    = 4,
  parameter int          PWM_CH    = 2,
  parameter int          SCAN_DIV  = 1024,
  parameter int          PWM_DIV   = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  mmio_out_ctrl_if.slave      bus,
  output logic [DIGITS-1:0]   o_ds_en,
  output logic [6:0]          o_ds_seg,
  output logic [15:0]         o_led_out,
  output logic [PWM_CH-1:0]   o_pwm_out
);

  localparam int          SCW      = $clog2(SCAN_DIV);
  localparam int          IDW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int          PRW      = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [15:0] NREG     = 16'(4 + PWM_CH);
  localparam logic [31:0] DIG_MASK = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                                   : 32'((64'd1 << (4 * DIGITS)) - 64'd1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  logic [31:0]       r_disp;
  logic [15:0]       r_led;
  logic [1:0]        r_ctrl;
  logic [7:0]        r_duty   [PWM_CH];
  logic [7:0]        r_shadow [PWM_CH];
  logic [SCW-1:0]    r_scan_cnt;
  logic [IDW-1:0]    r_dig_idx;
  logic [PRW-1:0]    r_pwm_pre;
  logic [7:0]        r_pwm_cnt;
  logic [15:0]       r_rd_data;
  logic              r_rd_hit;
  logic [15:0]       r_led_out;
  logic [DIGITS-1:0] r_ds_en;
  logic [6:0]        r_ds_seg;
  logic [PWM_CH-1:0] r_pwm_out;

  logic [15:0]       w_wr_off;
  logic [15:0]       w_rd_off;
  logic              w_rd_in;
  logic [15:0]       w_rd_val;
  logic              w_slot_end;
  logic              w_idx_last;
  logic [3:0]        w_nib;
  logic              w_lz;
  logic [6:0]        w_seg;
  logic [DIGITS-1:0] w_onehot;
  logic              w_pwm_tick;

  assign w_wr_off = bus.wr_addr - BASE_ADDR;
  assign w_rd_off = bus.rd_addr - BASE_ADDR;
  assign w_rd_in  = (w_rd_off < NREG);

  // Nibbles for absent digits are masked on write so they always read back 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_disp <= '0;
      r_led  <= '0;
      r_ctrl <= 2'b01;
      for (int i = 0; i < PWM_CH; i++) r_duty[i] <= 8'd0;
    end else if (bus.wr_en) begin
      case (w_wr_off)
        16'd0:   r_disp[15:0]  <= bus.wr_data & DIG_MASK[15:0];
        16'd1:   r_disp[31:16] <= bus.wr_data & DIG_MASK[31:16];
        16'd2:   r_led         <= bus.wr_data;
        16'd3:   r_ctrl        <= bus.wr_data[1:0];
        default: ;
      endcase
      for (int i = 0; i < PWM_CH; i++)
        if (w_wr_off == 16'(4 + i)) r_duty[i] <= bus.wr_data[7:0];
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (w_rd_off)
      16'd0:   w_rd_val = r_disp[15:0];
      16'd1:   w_rd_val = r_disp[31:16];
      16'd2:   w_rd_val = r_led;
      16'd3:   w_rd_val = {14'd0, r_ctrl};
      default: ;
    endcase
    for (int i = 0; i < PWM_CH; i++)
      if (w_rd_off == 16'(4 + i)) w_rd_val = {8'd0, r_duty[i]};
  end

  // Read samples pre-write state, so a same-cycle store to the same register returns the old value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
      r_rd_hit  <= 1'b0;
      r_led_out <= '0;
    end else begin
      r_rd_data <= (bus.rd_en && w_rd_in) ? w_rd_val : 16'd0;
      r_rd_hit  <= bus.rd_en && w_rd_in;
      r_led_out <= r_led;
    end
  end

  assign w_slot_end = (r_scan_cnt == SCW'(SCAN_DIV - 1));
  assign w_idx_last = (r_dig_idx == IDW'(DIGITS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= '0;
    end else if (r_ctrl[0]) begin
      r_scan_cnt <= w_slot_end ? '0 : r_scan_cnt + 1'b1;
      if (w_slot_end) r_dig_idx <= w_idx_last ? '0 : r_dig_idx + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [31:0] w_shift;
  assign w_shift = r_disp >> {r_dig_idx, 2'b00};
  assign w_nib   = w_shift[3:0];
  assign w_lz    = (r_dig_idx != '0) && (w_shift == 32'd0);
`else
  assign w_nib   = r_disp[{r_dig_idx, 2'b00} +: 4];
  assign w_lz    = 1'b0;
`endif

  assign w_seg    = (r_ctrl[1] || w_lz) ? 7'd0 : hex7(w_nib);
  assign w_onehot = DIGITS'(1) << r_dig_idx;

  // Count 0 of every slot is a dark guard cycle so the previous digit cannot ghost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ds_en  <= '0;
      r_ds_seg <= '0;
    end else if (!r_ctrl[0] || (r_scan_cnt == '0)) begin
      r_ds_en  <= '0;
      r_ds_seg <= '0;
    end else begin
      r_ds_en  <= w_onehot;
      r_ds_seg <= w_seg;
    end
  end

  assign w_pwm_tick = (r_pwm_pre == PRW'(PWM_DIV - 1));

  // Duty registers reach the comparators only at the 255->0 wrap, keeping each period intact.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwm_pre <= '0;
      r_pwm_cnt <= '0;
      for (int i = 0; i < PWM_CH; i++) r_shadow[i] <= 8'd0;
    end else begin
      r_pwm_pre <= w_pwm_tick ? '0 : r_pwm_pre + 1'b1;
      if (w_pwm_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
        if (r_pwm_cnt == 8'hFF)
          for (int i = 0; i < PWM_CH; i++) r_shadow[i] <= r_duty[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwm_out <= '0;
    end else begin
      for (int i = 0; i < PWM_CH; i++) r_pwm_out[i] <= (r_pwm_cnt < r_shadow[i]);
    end
  end

  assign bus.rd_data = r_rd_data;
  assign bus.rd_hit  = r_rd_hit;
  assign o_ds_en     = r_ds_en;
  assign o_ds_seg    = r_ds_seg;
  assign o_led_out   = r_led_out;
  assign o_pwm_out   = r_pwm_out;

endmodule

// File: tb/tb_mmio_out_ctrl.sv
// Directed bench for mmio_out_ctrl: DIGITS=4, PWM_CH=2, SCAN_DIV=4, PWM_DIV=1.
module tb_mmio_out_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mmio_out_ctrl_if bus ();
  logic [3:0]  ds_en;
  logic [6:0]  ds_seg;
  logic [15:0] led_out;
  logic [1:0]  pwm_out;

  mmio_out_ctrl #(
    .BASE_ADDR(16'hFF00), .DIGITS(4), .PWM_CH(2), .SCAN_DIV(4), .PWM_DIV(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_ds_en(ds_en), .o_ds_seg(ds_seg), .o_led_out(led_out), .o_pwm_out(pwm_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [16:0] hd);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    @(negedge clk);
    hd = {bus.rd_hit, bus.rd_data};
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_sync(output logic ok);
    logic [3:0] prev;
    ok   = 1'b0;
    prev = ds_en;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (prev == 4'b0000 && ds_en == 4'b0001) ok = 1'b1;
      prev = ds_en;
    end
  endtask

  task automatic after_release(input string p);
    logic [16:0] hd;
    @(negedge clk);
    check({p, "_guard"}, {ds_en, ds_seg}, 32'h0);
    @(negedge clk);
    check({p, "_first_digit"}, {ds_en, ds_seg}, {4'b0001, 7'h3F});
    rd(16'hFF03, hd);
    check({p, "_ctrl_read"}, hd, {1'b1, 16'h0001});
    rd(16'hFF02, hd);
    check({p, "_led_read"}, hd, {1'b1, 16'h0000});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [16:0] hd;
    logic        ok;
    logic        prev0;
    logic [6:0]  exp_seg [4];
    logic [6:0]  lz_seg;
    int          nz, segnz, ennz, hi0, hi1, hch1;

    exp_seg[0] = 7'h71; exp_seg[1] = 7'h77; exp_seg[2] = 7'h5B; exp_seg[3] = 7'h06;
`ifdef LEADING_ZERO_BLANK_EN
    lz_seg = 7'h00;
`else
    lz_seg = 7'h3F;
`endif
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;

    @(negedge clk);
    check("rst_ds", {ds_en, ds_seg}, 32'h0);
    check("rst_led_pwm", {led_out, pwm_out}, 32'h0);
    check("rst_rd", {bus.rd_hit, bus.rd_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    after_release("rst1");

    // Readback and window edges
    wr(16'hFF02, 16'hBEEF);
    rd(16'hFF02, hd);
    check("led_readback", hd, {1'b1, 16'hBEEF});
    check("led_out", led_out, 16'hBEEF);
    @(negedge clk);
    check("rd_idle_zero", {bus.rd_hit, bus.rd_data}, 32'h0);
    wr(16'hFF06, 16'hFFFF);
    rd(16'hFF06, hd);
    check("rd_above_window", hd, 32'h0);
    rd(16'hFEFF, hd);
    check("rd_below_window", hd, 32'h0);
    rd(16'hFF02, hd);
    check("led_unchanged", hd, {1'b1, 16'hBEEF});

    bus.wr_en = 1'b1; bus.wr_addr = 16'hFF02; bus.wr_data = 16'h1234;
    bus.rd_en = 1'b1; bus.rd_addr = 16'hFF02;
    @(negedge clk);
    hd = {bus.rd_hit, bus.rd_data};
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("same_cycle_old", hd, {1'b1, 16'hBEEF});
    rd(16'hFF02, hd);
    check("same_cycle_new", hd, {1'b1, 16'h1234});
    wr(16'hFF01, 16'hFFFF);
    rd(16'hFF01, hd);
    check("absent_digits_read0", hd, {1'b1, 16'h0000});

    // Digit scan
    wr(16'hFF00, 16'h12AF);
    rd(16'hFF00, hd);
    check("digits_readback", hd, {1'b1, 16'h12AF});
    wait_sync(ok);
    check("scan_sync", ok, 1);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 3; c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        check($sformatf("scan_d%0d_c%0d", s, c), {ds_en, ds_seg}, {4'(1 << s), exp_seg[s]});
      end
      @(negedge clk);
      check($sformatf("scan_guard%0d", s), {ds_en, ds_seg}, 32'h0);
    end
    @(negedge clk);
    check("scan_wrap", {ds_en, ds_seg}, {4'b0001, 7'h71});

    // Freeze mid-slot and resume
    wait_sync(ok);
    check("freeze_sync", ok, 1);
    wr(16'hFF03, 16'h0000);
    nz = 0;
    repeat (50) begin
      @(negedge clk);
      if (ds_en != 4'b0 || ds_seg != 7'b0) nz++;
    end
    check("freeze_dark", nz, 0);
    wr(16'hFF03, 16'h0001);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (ds_en != 4'b0) ok = 1'b1;
    end
    check("freeze_resume", {ok, ds_en, ds_seg}, {1'b1, 4'b0001, 7'h71});

    // Blank-all keeps scanning; unused CTRL bits read 0
    wr(16'hFF03, 16'hFFFF);
    rd(16'hFF03, hd);
    check("ctrl_bits", hd, {1'b1, 16'h0003});
    segnz = 0; ennz = 0;
    repeat (12) begin
      @(negedge clk);
      if (ds_seg != 7'b0) segnz++;
      if (ds_en != 4'b0) ennz++;
    end
    check("blank_seg", segnz, 0);
    check("blank_en_active", ennz, 9);
    wr(16'hFF03, 16'h0001);

    // Leading zeros
    wr(16'hFF00, 16'h0030);
    wait_sync(ok);
    check("lz_sync", ok, 1);
    check("lz_d0", {ds_en, ds_seg}, {4'b0001, 7'h3F});
    repeat (4) @(negedge clk);
    check("lz_d1", {ds_en, ds_seg}, {4'b0010, 7'h4F});
    repeat (4) @(negedge clk);
    check("lz_d2", {ds_en, ds_seg}, {4'b0100, lz_seg});
    repeat (4) @(negedge clk);
    check("lz_d3", {ds_en, ds_seg}, {4'b1000, lz_seg});

    // PWM glitch-free duty update
    wr(16'hFF04, 16'hAB40);
    rd(16'hFF04, hd);
    check("duty_upper_bits", hd, {1'b1, 16'h0040});
    ok = 1'b0;
    prev0 = pwm_out[0];
    for (int k = 0; k < 600 && !ok; k++) begin
      @(negedge clk);
      if (!prev0 && pwm_out[0]) ok = 1'b1;
      prev0 = pwm_out[0];
    end
    check("pwm_rise", ok, 1);
    hi0 = 0; hi1 = 0; hch1 = 0;
    for (int j = 0; j < 512; j++) begin
      if (j > 0) @(negedge clk);
      if (pwm_out[0]) begin
        if (j < 256) hi0++;
        else hi1++;
      end
      if (pwm_out[1]) hch1++;
      if (j == 100) begin
        bus.wr_en = 1'b1; bus.wr_addr = 16'hFF04; bus.wr_data = 16'h00C0;
      end
      if (j == 101) bus.wr_en = 1'b0;
    end
    check("pwm_period_64", hi0, 64);
    check("pwm_period_192", hi1, 192);
    check("pwm_ch1_low", hch1, 0);
    wr(16'hFF04, 16'h0000);
    repeat (520) @(negedge clk);
    hi0 = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out[0]) hi0++;
    end
    check("pwm_duty0_low", hi0, 0);

    // Asynchronous reset mid-run
    wr(16'hFF04, 16'h00FF);
    repeat (20) @(negedge clk);
    check("pre_reset_led", led_out, 16'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ds", {ds_en, ds_seg}, 32'h0);
    check("async_led", led_out, 32'h0);
    check("async_pwm", pwm_out, 32'h0);
    check("async_rd", {bus.rd_hit, bus.rd_data}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    after_release("rst2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
